display_7_scan: RTL and testbench

- Parametrised multiplexed N-digit seven-segment driver; successor to the single-digit BCD decoder.
- Captures a packed BCD word into a shadow register and scans the digits time-multiplexed over one shared segment bus, with one-hot digit enables.
- Adds inter-digit anti-ghosting blanking, optional leading-zero suppression and selectable output polarity.
- Sits between the clock counters and the board display pins.

---
 rtl/display_7_scan.sv | 109 ++++++++++
 tb/tb_display_7_scan.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/display_7_scan.sv
// display_7_scan: multiplexed N-digit seven-segment scanner with anti-ghost blanking, leading-zero suppression and output polarity.
// Optional blinking per digit is enabled by defining DISPLAY_7_SCAN_BLINK_EN.
module display_7_scan #(
    parameter int NUM_DIGITS     = 6,
    parameter int PRESCALE       = 50000,
    parameter int BLANK_CYCLES   = 1,
    parameter bit LZ_BLANK       = 1,
    parameter bit SEG_ACTIVE_LOW = 0,
    parameter bit DIG_ACTIVE_LOW = 0
`ifdef DISPLAY_7_SCAN_BLINK_EN
    ,
    parameter int BLINK_DIV      = 25000000
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    load,
`ifdef DISPLAY_7_SCAN_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_sel
);
    localparam int CW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_ACTIVE_LOW}};

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   dig_q, dig_d;
    logic                    wrap, dark, hide, zero_run;
    logic [3:0]              cur;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0: decode = 7'b1111110;
            4'd1: decode = 7'b0110000;
            4'd2: decode = 7'b1101101;
            4'd3: decode = 7'b1111001;
            4'd4: decode = 7'b0110011;
            4'd5: decode = 7'b1011011;
            4'd6: decode = 7'b1011111;
            4'd7: decode = 7'b1110000;
            4'd8: decode = 7'b1111111;
            4'd9: decode = 7'b1111011;
            default: decode = 7'b0000000;
        endcase
    endfunction

`ifdef DISPLAY_7_SCAN_BLINK_EN
    localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
    logic [BW-1:0] bcnt_q;
    logic          phase_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            bcnt_q  <= bcnt_q == BW'(BLINK_DIV - 1) ? '0 : bcnt_q + BW'(1);
            phase_q <= bcnt_q == BW'(BLINK_DIV - 1) ? ~phase_q : phase_q;
        end
    end
`endif

    always_comb begin
        wrap     = cnt_q == CW'(PRESCALE - 1);
        cnt_d    = wrap ? '0 : cnt_q + CW'(1);
        idx_d    = !wrap ? idx_q : (idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + IW'(1));
        shadow_d = load ? bcd_in : shadow_q;
        cur      = shadow_q[{idx_q, 2'b00} +: 4];
        dark     = int'(cnt_q) < BLANK_CYCLES;
        // A digit is a leading zero when it and every more significant digit are zero.
        zero_run = 1'b1;
        hide     = 1'b0;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            zero_run = zero_run && shadow_q[4*k +: 4] == 4'd0;
            if (IW'(k) == idx_q) hide = LZ_BLANK && zero_run;
        end
`ifdef DISPLAY_7_SCAN_BLINK_EN
        hide = hide || (phase_q && blink_mask[idx_q]);
`endif
        seg_d = dark ? SEG_OFF : (hide ? 7'b0 : decode(cur)) ^ SEG_OFF;
        dig_d = dark ? DIG_OFF : (NUM_DIGITS'(1) << idx_q) ^ DIG_OFF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            seg_q    <= SEG_OFF;
            dig_q    <= DIG_OFF;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            seg_q    <= seg_d;
            dig_q    <= dig_d;
        end
    end

    assign seg_out = seg_q;
    assign dig_sel = dig_q;
endmodule

// File: tb/tb_display_7_scan.sv
// tb_display_7_scan: scoreboard bench for display_7_scan; one active-high LZ instance and one
// inverted-polarity instance without zero suppression run side by side on the same stimulus.
module tb_display_7_scan;
    localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101, S3 = 7'b1111001;
    localparam logic [6:0] S4 = 7'b0110011, S5 = 7'b1011011, S7 = 7'b1110000, S8 = 7'b1111111;
    localparam logic [6:0] SB = 7'b0000000;

    logic        clk = 1'b0, rst = 1'b1, load = 1'b0;
    logic [15:0] bcd = 16'h0;
    logic [6:0]  seg_a, seg_b;
    logic [3:0]  dig_a, dig_b;
`ifdef DISPLAY_7_SCAN_BLINK_EN
    logic [3:0]  blink_mask = 4'b0000;
`endif

    typedef struct {
        logic [6:0] sa;
        logic [3:0] dig;
        logic [6:0] sb;
        int         ph;
    } exp_t;

    exp_t q[$];
    int   compared = 0, mismatched = 0, ph = 0;

    always #5 clk = ~clk;

    display_7_scan #(.NUM_DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(1), .LZ_BLANK(1),
                     .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) dut_a (
        .clk(clk), .rst(rst), .bcd_in(bcd), .load(load),
`ifdef DISPLAY_7_SCAN_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .seg_out(seg_a), .dig_sel(dig_a));

    display_7_scan #(.NUM_DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(1), .LZ_BLANK(0),
                     .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) dut_b (
        .clk(clk), .rst(rst), .bcd_in(bcd), .load(load),
`ifdef DISPLAY_7_SCAN_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .seg_out(seg_b), .dig_sel(dig_b));

    task automatic push(input logic [6:0] sa, input logic [3:0] dg, input logic [6:0] sb);
        exp_t e;
        e.sa = sa; e.dig = dg; e.sb = sb; e.ph = ph;
        q.push_back(e);
    endtask

    task automatic slot(input int k, input logic [6:0] a1, a2, a3, b1, b2, b3);
        logic [3:0] d;
        d = 4'b0001 << k;
        push(SB, 4'b0000, SB);
        push(a1, d, b1);
        push(a2, d, b2);
        push(a3, d, b3);
    endtask

    // sa/sb pack digit k segments at [7k+6:7k]; load is dropped after the first edge.
    task automatic frame(input logic [27:0] sa, input logic [27:0] sb);
        for (int k = 0; k < 4; k++)
            slot(k, sa[7*k +: 7], sa[7*k +: 7], sa[7*k +: 7], sb[7*k +: 7], sb[7*k +: 7], sb[7*k +: 7]);
        @(negedge clk);
        load = 1'b0;
        repeat (15) @(negedge clk);
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                logic [6:0] eb;
                logic [3:0] ed;
                e  = q.pop_front();
                eb = ~e.sb;
                ed = ~e.dig;
                compared++;
                if (seg_a !== e.sa || dig_a !== e.dig || seg_b !== eb || dig_b !== ed) begin
                    mismatched++;
                    $display("FAIL ph%0d t=%0t: got seg_a=%b dig_a=%b seg_b=%b dig_b=%b, expected %b %b %b %b",
                             e.ph, $time, seg_a, dig_a, seg_b, dig_b, e.sa, e.dig, eb, ed);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ph = 1;
        @(negedge clk);
        repeat (3) push(SB, 4'b0000, SB);
        repeat (3) @(negedge clk);
        ph = 2; rst = 1'b0; bcd = 16'h1234; load = 1'b1;
        frame({S1, S2, S3, S4}, {S1, S2, S3, S4});
        ph = 3;
        frame({S1, S2, S3, S4}, {S1, S2, S3, S4});
        ph = 4; bcd = 16'h0007; load = 1'b1;
        frame({SB, SB, SB, S7}, {S0, S0, S0, S7});
        ph = 5; bcd = 16'h0000; load = 1'b1;
        frame({SB, SB, SB, S0}, {S0, S0, S0, S0});
        ph = 6; bcd = 16'h00A5; load = 1'b1;
        frame({SB, SB, SB, S5}, {S0, S0, SB, S5});
        ph = 7; bcd = 16'h1020; load = 1'b1;
        frame({S1, S0, S2, S0}, {S1, S0, S2, S0});
        ph = 8; bcd = 16'h1234; load = 1'b1;
        frame({S1, S2, S3, S4}, {S1, S2, S3, S4});
        ph = 9;
        slot(0, S4, S4, S4, S4, S4, S4);
        slot(1, S3, S3, S8, S3, S3, S8);
        slot(2, S8, S8, S8, S8, S8, S8);
        slot(3, S8, S8, S8, S8, S8, S8);
        repeat (6) @(negedge clk);
        bcd = 16'h8888; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (9) @(negedge clk);
        ph = 10;
        slot(0, S8, S8, S8, S8, S8, S8);
        slot(1, S8, S8, S8, S8, S8, S8);
        push(SB, 4'b0000, SB);
        push(S8, 4'b0100, S8);
        push(S8, 4'b0100, S8);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #3;
        push(SB, 4'b0000, SB);
        push(SB, 4'b0000, SB);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        ph = 11; rst = 1'b0;
        frame({SB, SB, SB, S0}, {S0, S0, S0, S0});
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
